// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle core: byte-wide loadable instruction memory, 8-entry register file
// (R0 reads zero), ALU, jumps/branches, OUT strobe, HALT state and sticky illegal-opcode flag.
module cpu_core_param #(
    parameter  int DATA_W     = 8,
    parameter  int IMEM_DEPTH = 16,
    localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic [DATA_W-1:0] core_output,
    output logic              out_valid,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_LO,
        S_FETCH_HI,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LI   = 4'd7;
    localparam logic [3:0] OP_OUT  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    logic [7:0]        imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs [8];
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] result;
    logic              take_branch;

    logic [3:0]        op;
    logic [2:0]        rd, rs1, rs2;
    logic [5:0]        imm6;
    logic [8:0]        imm9;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic [DATA_W-1:0] alu_y;
    logic              writes_rd;
    logic              branch_y;
    logic              op_illegal;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] target;

    assign op   = ir[15:12];
    assign rd   = ir[11:9];
    assign rs1  = ir[8:6];
    assign rs2  = ir[5:3];
    assign imm6 = ir[5:0];
    assign imm9 = ir[8:0];

    assign rs1_val  = (rs1 == 3'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 3'd0) ? '0 : regs[rs2];
    assign pc_plus1 = pc + ADDR_W'(1);
    assign target   = ADDR_W'(imm6);
    assign pc_dbg   = pc;

    assign op_illegal = (op >= 4'd11) && (op <= 4'd14);
    assign branch_y   = (op == OP_JMP) || ((op == OP_JZ) && (rs1_val == '0));

    // NOTE: every output of an always_comb gets a default first, otherwise an uncovered opcode infers a latch.
    always_comb begin
        alu_y     = '0;
        writes_rd = 1'b0;
        case (op)
            OP_ADD:  begin alu_y = rs1_val + rs2_val;         writes_rd = 1'b1; end
            OP_SUB:  begin alu_y = rs1_val - rs2_val;         writes_rd = 1'b1; end
            OP_AND:  begin alu_y = rs1_val & rs2_val;         writes_rd = 1'b1; end
            OP_OR:   begin alu_y = rs1_val | rs2_val;         writes_rd = 1'b1; end
            OP_XOR:  begin alu_y = rs1_val ^ rs2_val;         writes_rd = 1'b1; end
            OP_ADDI: begin alu_y = rs1_val + DATA_W'(imm6);   writes_rd = 1'b1; end
            OP_LI:   begin alu_y = DATA_W'(imm9);             writes_rd = 1'b1; end
            default: ;
        endcase
    end

    // NOTE: the instruction memory has no reset so a program survives rst and maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && load_en)
            imem[load_addr] <= load_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            result      <= '0;
            take_branch <= 1'b0;
            core_output <= '0;
            out_valid   <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (run)
                        state <= S_FETCH_LO;
                end
                S_FETCH_LO: begin
                    ir[7:0] <= imem[pc];
                    state   <= S_FETCH_HI;
                end
                S_FETCH_HI: begin
                    ir[15:8] <= imem[pc_plus1];
                    pc       <= pc + ADDR_W'(2);
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    result      <= alu_y;
                    take_branch <= branch_y;
                    if (op_illegal)
                        illegal <= 1'b1;
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    // R0 is never written, so its reset zero is permanent
                    if (writes_rd && rd != 3'd0)
                        regs[rd] <= result;
                    if (op == OP_OUT) begin
                        core_output <= rs1_val;
                        out_valid   <= 1'b1;
                    end
                    if (take_branch)
                        pc <= target;
                    state <= S_FETCH_LO;
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: an instruction-level model expands each program into a per-cycle
// expectation timeline that one negedge process compares against the core.
module tb_cpu_core_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MAXC  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic [DW-1:0] core_output;
    logic          out_valid;
    logic          halted;
    logic          illegal;
    logic [AW-1:0] pc_dbg;

    cpu_core_param #(.DATA_W(DW), .IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .run(run), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .core_output(core_output), .out_valid(out_valid),
        .halted(halted), .illegal(illegal), .pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]    mem_m     [DEPTH];
    logic [AW-1:0] exp_pc    [MAXC];
    logic [DW-1:0] exp_out   [MAXC];
    logic          exp_valid [MAXC];
    logic          exp_halt  [MAXC];
    logic          exp_ill   [MAXC];
    int            cyc    = 0;
    bit            cmp_en = 1'b0;
    logic [DW-1:0] outs_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int c, input int p, input logic [DW-1:0] o,
                       input logic v, input logic h, input logic i);
        if (c < MAXC) begin
            exp_pc[c]    = AW'(p);
            exp_out[c]   = o;
            exp_valid[c] = v;
            exp_halt[c]  = h;
            exp_ill[c]   = i;
        end
    endtask

    // Executes the program in mem_m one instruction at a time; each takes 4 cycles.
    task automatic build_model();
        logic [DW-1:0] r [8];
        logic [DW-1:0] o;
        logic [15:0]   w;
        logic          ill, ill_n, pv, wr;
        int p, np, t, op, rd, rs1, rs2, imm6, imm9, a, b, val;
        for (int i = 0; i < 8; i++) r[i] = '0;
        p = 0; o = '0; ill = 1'b0; pv = 1'b0; t = 0;
        while (t < MAXC) begin
            w    = {mem_m[(p + 1) % DEPTH], mem_m[p]};
            op   = int'(w[15:12]);
            rd   = int'(w[11:9]);
            rs1  = int'(w[8:6]);
            rs2  = int'(w[5:3]);
            imm6 = int'(w[5:0]);
            imm9 = int'(w[8:0]);
            a    = int'(r[rs1]);
            b    = int'(r[rs2]);
            np   = (p + 2) % DEPTH;
            put(t,     p,  o, pv,   1'b0, ill);
            put(t + 1, p,  o, 1'b0, 1'b0, ill);
            put(t + 2, np, o, 1'b0, 1'b0, ill);
            if (op == 15) begin
                for (int c = t + 3; c < MAXC; c++) put(c, np, o, 1'b0, 1'b1, ill);
                break;
            end
            ill_n = ill || (op >= 11 && op <= 14);
            put(t + 3, np, o, 1'b0, 1'b0, ill_n);
            pv = 1'b0; wr = 1'b0; val = 0;
            case (op)
                1:  begin wr = 1'b1; val = a + b;    end
                2:  begin wr = 1'b1; val = a - b;    end
                3:  begin wr = 1'b1; val = a & b;    end
                4:  begin wr = 1'b1; val = a | b;    end
                5:  begin wr = 1'b1; val = a ^ b;    end
                6:  begin wr = 1'b1; val = a + imm6; end
                7:  begin wr = 1'b1; val = imm9;     end
                8:  begin o = r[rs1]; pv = 1'b1;     end
                9:  np = imm6 % DEPTH;
                10: if (a == 0) np = imm6 % DEPTH;
                default: ;
            endcase
            if (wr && rd != 0) r[rd] = val[DW-1:0];
            p = np; ill = ill_n; t += 4;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (cyc < MAXC) begin
                check($sformatf("pc_dbg@%0d", cyc),      pc_dbg,      exp_pc[cyc]);
                check($sformatf("core_output@%0d", cyc), core_output, exp_out[cyc]);
                check($sformatf("out_valid@%0d", cyc),   out_valid,   exp_valid[cyc]);
                check($sformatf("halted@%0d", cyc),      halted,      exp_halt[cyc]);
                check($sformatf("illegal@%0d", cyc),     illegal,     exp_ill[cyc]);
            end
            if (out_valid) outs_q.push_back(core_output);
            cyc++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        @(negedge clk);
        check({tag, "_pc"},     pc_dbg,      0);
        check({tag, "_out"},    core_output, 0);
        check({tag, "_valid"},  out_valid,   0);
        check({tag, "_halted"}, halted,      0);
        check({tag, "_ill"},    illegal,     0);
        @(posedge clk); #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
    endtask

    task automatic put_word(input int addr, input logic [15:0] w);
        mem_m[addr]     = w[7:0];
        mem_m[addr + 1] = w[15:8];
    endtask

    // Byte 0 is left for run_prog, which writes it in the same cycle run is sampled.
    task automatic load_all();
        for (int i = 1; i < DEPTH; i++) begin
            load_en = 1'b1; load_addr = AW'(i); load_data = mem_m[i];
            @(posedge clk); #1;
        end
        load_en = 1'b0;
    endtask

    task automatic run_prog(input int n, input int glitch_at, input int rst_at);
        build_model();
        load_en = 1'b1; load_addr = '0; load_data = mem_m[0]; run = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0; run = 1'b0;
        outs_q.delete();
        cyc = 0; cmp_en = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (c == glitch_at) begin
                load_en = 1'b1; load_addr = AW'(1); load_data = 8'h80; run = 1'b1;
            end
            if (c == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            load_en = 1'b0; run = 1'b0; rst = 1'b0;
        end
        cmp_en = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int n, input logic [3*DW-1:0] vals);
        check({tag, "_count"}, outs_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < outs_q.size())
                check($sformatf("%s_val%0d", tag, i), outs_q[i], vals[i*DW +: DW]);
        end
    endtask

    initial begin
        do_reset();
        check_idle_zero("reset");

        // Basic add and output
        clear_prog();
        mem_m[0] = 8'h05; mem_m[1] = 8'h72; mem_m[2] = 8'h03; mem_m[3] = 8'h74;
        mem_m[4] = 8'h50; mem_m[5] = 8'h16; mem_m[6] = 8'hC0; mem_m[7] = 8'h80;
        mem_m[8] = 8'h00; mem_m[9] = 8'hF0;
        load_all();
        run_prog(30, -1, -1);
        check("model_valid15", exp_valid[15], 0);
        check("model_valid16", exp_valid[16], 1);
        check("model_valid17", exp_valid[17], 0);
        check("model_out16",   exp_out[16],   8);
        check("model_halt20",  exp_halt[20],  1);
        check("model_pc25",    exp_pc[25],    10);
        check_outs("add", 1, 24'd8);

        // Wrap-around, ADD then SUB
        do_reset();
        clear_prog();
        put_word(0, 16'h72FF); put_word(2, 16'h7401); put_word(4, 16'h1650);
        put_word(6, 16'h80C0); put_word(8, 16'hF000);
        load_all();
        run_prog(30, -1, -1);
        check_outs("wrap_add", 1, 24'h00);

        do_reset();
        put_word(0, 16'h7200); put_word(4, 16'h2650);
        load_all();
        run_prog(30, -1, -1);
        check_outs("wrap_sub", 1, 24'hFF);

        // R0 hardwired zero
        do_reset();
        clear_prog();
        put_word(0, 16'h7007); put_word(2, 16'h8000); put_word(4, 16'hF000);
        load_all();
        run_prog(20, -1, -1);
        check_outs("r0", 1, 24'h00);

        // Branch loop: counts R1 down from 3, JZ exits to HALT at 12
        do_reset();
        clear_prog();
        put_word(0, 16'h7203); put_word(2, 16'h7401); put_word(4, 16'h2250);
        put_word(6, 16'h8040); put_word(8, 16'hA04C); put_word(10, 16'h9004);
        put_word(12, 16'hF000);
        load_all();
        run_prog(70, -1, -1);
        check_outs("loop", 3, {8'd0, 8'd1, 8'd2});
        check("loop_halted", halted, 1);
        check("loop_pc", pc_dbg, 14);

        // Illegal opcode: sticky flag, execution continues
        do_reset();
        clear_prog();
        put_word(0, 16'hB000); put_word(2, 16'h8000); put_word(4, 16'hF000);
        load_all();
        run_prog(20, -1, -1);
        check("ill_sticky", illegal, 1);
        check_outs("ill", 1, 24'h00);
        do_reset();
        check_idle_zero("reset_after_halt");

        // Load gating: a write attempted in FETCH_HI must not land
        clear_prog();
        put_word(0, 16'h7205); put_word(2, 16'h8040); put_word(4, 16'hF000);
        load_all();
        run_prog(20, 1, -1);
        check_outs("gate_run1", 1, 24'd5);
        do_reset();
        run_prog(20, -1, -1);
        check_outs("gate_run2", 1, 24'd5);

        // Reset during EXEC of ADD (cycle 10)
        do_reset();
        clear_prog();
        put_word(0, 16'h7205); put_word(2, 16'h7403); put_word(4, 16'h1650);
        put_word(6, 16'h80C0); put_word(8, 16'hF000);
        load_all();
        run_prog(11, -1, 10);
        check_idle_zero("mid_rst");
        check("mid_rst_no_out", outs_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
        check_idle_zero("mid_rst_idle");
        clear_prog();
        put_word(0, 16'h80C0); put_word(2, 16'hF000);
        load_all();
        run_prog(20, -1, -1);
        check_outs("mid_rst_r3", 1, 24'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
